// File: rtl/piradip_util_pkg.sv
// Shared helpers for the piradip stream utilities: counter-width function and
// the drop-counter width.
`default_nettype none

package piradip_util_pkg;

  localparam int DROP_COUNT_WIDTH = 32;

  // Bits needed to hold values 0..value-1; callers pass DEPTH+1 for occupancy counters.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/piradip_sdp_ram.sv
// Simple dual-port RAM: synchronous write port, asynchronous (combinational) read port.
`default_nettype none

module piradip_sdp_ram
  import piradip_util_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 33
) (
  input  logic                      clk,
  input  logic                      we_i,
  input  logic [clog2(DEPTH)-1:0]   waddr_i,
  input  logic [WIDTH-1:0]          wdata_i,
  input  logic [clog2(DEPTH)-1:0]   raddr_i,
  output logic [WIDTH-1:0]          rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Contents are intentionally not reset; validity is tracked by the owner's pointers.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/piradip_valid_to_axis.sv
// Buffers a free-running valid/data stream into a FWFT FIFO presented as an
// AXI4-Stream master; words arriving while full are dropped and counted.
`default_nettype none

module piradip_valid_to_axis
  import piradip_util_pkg::*;
#(
  parameter int IN_BAND_WIDTH     = 32,
  parameter int OUT_OF_BAND_WIDTH = 1,
  parameter int DEPTH             = 16
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  in_valid,
  input  logic [IN_BAND_WIDTH+OUT_OF_BAND_WIDTH-1:0] in_data,
  output logic                                  m_axis_tvalid,
  input  logic                                  m_axis_tready,
  output logic [IN_BAND_WIDTH-1:0]              m_axis_tdata,
  output logic [OUT_OF_BAND_WIDTH-1:0]          m_axis_tuser,
  input  logic                                  clear_overflow,
  output logic                                  overflow,
  output logic [DROP_COUNT_WIDTH-1:0]           drop_count,
  output logic [clog2(DEPTH+1)-1:0]             level
);

  localparam int ADDR_W  = clog2(DEPTH);
  localparam int LEVEL_W = clog2(DEPTH+1);
  localparam int DATA_W  = IN_BAND_WIDTH + OUT_OF_BAND_WIDTH;

  logic [ADDR_W-1:0]           wptr_q, wptr_d;
  logic [ADDR_W-1:0]           rptr_q, rptr_d;
  logic [LEVEL_W-1:0]          level_q, level_d;
  logic                        overflow_q, overflow_d;
  logic [DROP_COUNT_WIDTH-1:0] drop_count_q, drop_count_d;

  logic              pop;
  logic              push;
  logic              drop;
  logic [DATA_W-1:0] head;

  // Full-and-popping still accepts, so sustained push+pop never drops.
  assign pop  = m_axis_tvalid && m_axis_tready;
  assign push = in_valid && !reset && ((level_q < LEVEL_W'(DEPTH)) || pop);
  assign drop = in_valid && !push;

  piradip_sdp_ram #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (push),
    .waddr_i (wptr_q),
    .wdata_i (in_data),
    .raddr_i (rptr_q),
    .rdata_o (head)
  );

  always_comb begin
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    level_d      = level_q;
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;

    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;

    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    // A drop coinciding with a clear wins: the flag stays set and the count restarts at 1.
    if (clear_overflow) begin
      overflow_d   = drop;
      drop_count_d = drop ? DROP_COUNT_WIDTH'(1) : '0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_count_q != '1) drop_count_d = drop_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      level_q      <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      level_q      <= level_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign m_axis_tvalid = (level_q != '0);
  assign m_axis_tdata  = head[IN_BAND_WIDTH-1:0];
  assign m_axis_tuser  = head[DATA_W-1:IN_BAND_WIDTH];
  assign overflow      = overflow_q;
  assign drop_count    = drop_count_q;
  assign level         = level_q;

endmodule

`default_nettype wire

// File: tb/tb_piradip_valid_to_axis.sv
// Self-checking bench for piradip_valid_to_axis (DEPTH=16, 32-bit data, 1-bit tuser).
`default_nettype none

module tb_piradip_valid_to_axis;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [32:0] in_data;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [31:0] m_axis_tdata;
  logic [0:0]  m_axis_tuser;
  logic        clear_overflow;
  logic        overflow;
  logic [31:0] drop_count;
  logic [4:0]  level;

  int errors = 0;
  int checks = 0;

  piradip_valid_to_axis #(
    .IN_BAND_WIDTH     (32),
    .OUT_OF_BAND_WIDTH (1),
    .DEPTH             (16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tuser   (m_axis_tuser),
    .clear_overflow (clear_overflow),
    .overflow       (overflow),
    .drop_count     (drop_count),
    .level          (level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [32:0] din;
    logic        rdy;
    logic        clr;
    logic        chk_data;
    logic        e_valid;
    logic [31:0] e_data;
    logic        e_user;
    logic [4:0]  e_level;
    logic        e_ovf;
    logic [31:0] e_dc;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive inputs, take one rising edge, and leave the outputs settled for sampling.
  task automatic step(input logic iv, input logic [32:0] din, input logic rdy, input logic clr);
    in_valid       = iv;
    in_data        = din;
    m_axis_tready  = rdy;
    clear_overflow = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic check_status(input string tag, input logic ev, input logic [4:0] el,
                              input logic eo, input logic [31:0] ed);
    check({tag, ".tvalid"}, 32'(m_axis_tvalid), 32'(ev));
    check({tag, ".level"}, 32'(level), 32'(el));
    check({tag, ".overflow"}, 32'(overflow), 32'(eo));
    check({tag, ".drop_count"}, drop_count, ed);
  endtask

  initial begin
    reset          = 1'b1;
    in_valid       = 1'b0;
    in_data        = '0;
    m_axis_tready  = 1'b0;
    clear_overflow = 1'b0;

    // Passthrough and idle vectors: expected values are post-edge state.
    vecs[0] = '{1'b1, {1'b1, 32'h0000_0001}, 1'b1, 1'b0, 1'b1, 1'b1, 32'h1, 1'b1, 5'd1, 1'b0, 32'd0};
    vecs[1] = '{1'b1, {1'b0, 32'h0000_0002}, 1'b1, 1'b0, 1'b1, 1'b1, 32'h2, 1'b0, 5'd1, 1'b0, 32'd0};
    vecs[2] = '{1'b0, 33'h0,                 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 32'd0};
    vecs[3] = '{1'b0, 33'h0,                 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 32'd0};

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_status("reset", 1'b0, 5'd0, 1'b0, 32'd0);
    step(1'b0, '0, 1'b0, 1'b0);
    check_status("idle", 1'b0, 5'd0, 1'b0, 32'd0);

    for (int v = 0; v < 4; v++) begin
      step(vecs[v].iv, vecs[v].din, vecs[v].rdy, vecs[v].clr);
      check($sformatf("vec%0d.tvalid", v), 32'(m_axis_tvalid), 32'(vecs[v].e_valid));
      check($sformatf("vec%0d.level", v), 32'(level), 32'(vecs[v].e_level));
      check($sformatf("vec%0d.overflow", v), 32'(overflow), 32'(vecs[v].e_ovf));
      check($sformatf("vec%0d.drop_count", v), drop_count, vecs[v].e_dc);
      if (vecs[v].chk_data) begin
        check($sformatf("vec%0d.tdata", v), m_axis_tdata, vecs[v].e_data);
        check($sformatf("vec%0d.tuser", v), 32'(m_axis_tuser), 32'(vecs[v].e_user));
      end
    end

    // Fill with backpressure: 20 pushes, last 4 dropped.
    for (int i = 0; i < 20; i++)
      step(1'b1, {1'(i % 2), 32'h100 + 32'(i)}, 1'b0, 1'b0);
    check_status("fill", 1'b1, 5'd16, 1'b1, 32'd4);

    // Drain: only words 0..15 come out, in order.
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain%0d.tdata", i), m_axis_tdata, 32'h100 + 32'(i));
      check($sformatf("drain%0d.tuser", i), 32'(m_axis_tuser), 32'(i % 2));
      step(1'b0, '0, 1'b1, 1'b0);
    end
    check_status("drained", 1'b0, 5'd0, 1'b1, 32'd4);

    // Refill to full, then 3 more drops to reach a count of 7.
    for (int i = 0; i < 16; i++)
      step(1'b1, {1'b0, 32'h200 + 32'(i)}, 1'b0, 1'b0);
    check_status("refill", 1'b1, 5'd16, 1'b1, 32'd4);
    for (int i = 0; i < 3; i++)
      step(1'b1, {1'b1, 32'h2F0 + 32'(i)}, 1'b0, 1'b0);
    check_status("drop3", 1'b1, 5'd16, 1'b1, 32'd7);

    // Full with a simultaneous pop: incoming word accepted, no drop.
    step(1'b1, {1'b1, 32'h2FF}, 1'b1, 1'b0);
    check_status("fullpop", 1'b1, 5'd16, 1'b1, 32'd7);
    check("fullpop.tdata", m_axis_tdata, 32'h201);

    // Clear colliding with a drop: set wins, count restarts at 1.
    step(1'b1, {1'b0, 32'h3EE}, 1'b0, 1'b1);
    check_status("clrdrop", 1'b1, 5'd16, 1'b1, 32'd1);
    step(1'b0, '0, 1'b0, 1'b1);
    check_status("clralone", 1'b1, 5'd16, 1'b0, 32'd0);

    // Empty the FIFO via reset, then check head stability under backpressure.
    reset = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0);
    reset = 1'b0;
    check_status("rst2", 1'b0, 5'd0, 1'b0, 32'd0);
    step(1'b1, {1'b1, 32'h300}, 1'b0, 1'b0);
    step(1'b1, {1'b0, 32'h301}, 1'b0, 1'b0);
    check("bp.head", m_axis_tdata, 32'h300);
    for (int i = 2; i < 5; i++) begin
      step(1'b1, {1'b0, 32'h300 + 32'(i)}, 1'b0, 1'b0);
      check($sformatf("bp%0d.tdata", i), m_axis_tdata, 32'h300);
      check($sformatf("bp%0d.tuser", i), 32'(m_axis_tuser), 32'd1);
    end
    check_status("bp", 1'b1, 5'd5, 1'b0, 32'd0);

    // Mid-stream reset with in_valid high: everything discarded, input ignored.
    reset = 1'b1;
    step(1'b1, {1'b1, 32'h3FF}, 1'b0, 1'b0);
    check_status("midrst", 1'b0, 5'd0, 1'b0, 32'd0);
    reset = 1'b0;
    step(1'b0, '0, 1'b0, 1'b0);
    check_status("postrst", 1'b0, 5'd0, 1'b0, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
